// File: rtl/ifetch_unit.sv
// Instruction-fetch stage: fetches the word at pc_in over a req/ack memory port and
// hands it to the decoder over valid/ready, with redirect flush and sticky fault capture.
module ifetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int          CNT_W    = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [31:0]      pc_in,
  input  logic             redirect,
  output logic             pc_advance,
  output logic             imem_req,
  output logic [31:0]      imem_addr,
  input  logic             imem_ack,
  input  logic [31:0]      imem_rdata,
  input  logic             imem_err,
  output logic             ir_valid,
  input  logic             ir_ready,
  output logic [31:0]      ir,
  output logic [31:0]      ir_pc,
  output logic [5:0]       op,
  output logic [25:0]      jump_target,
  output logic [15:0]      imm,
  output logic             fetch_fault,
  output logic [31:0]      fault_pc,
  output logic [CNT_W-1:0] fetch_count
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_HOLD, S_FAULT} state_t;

  state_t            state_q, state_d;
  logic [31:0]       imem_addr_q, imem_addr_d;
  logic [31:0]       ir_q, ir_d;
  logic [31:0]       ir_pc_q, ir_pc_d;
  logic              fetch_fault_q, fetch_fault_d;
  logic [31:0]       fault_pc_q, fault_pc_d;
  logic [CNT_W-1:0]  fetch_count_q, fetch_count_d;
  logic              drop_q, drop_d;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q       <= S_IDLE;
      imem_addr_q   <= RESET_PC;
      ir_q          <= '0;
      ir_pc_q       <= '0;
      fetch_fault_q <= 1'b0;
      fault_pc_q    <= '0;
      fetch_count_q <= '0;
      drop_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      imem_addr_q   <= imem_addr_d;
      ir_q          <= ir_d;
      ir_pc_q       <= ir_pc_d;
      fetch_fault_q <= fetch_fault_d;
      fault_pc_q    <= fault_pc_d;
      fetch_count_q <= fetch_count_d;
      drop_q        <= drop_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    imem_addr_d   = imem_addr_q;
    ir_d          = ir_q;
    ir_pc_d       = ir_pc_q;
    fetch_fault_d = fetch_fault_q;
    fault_pc_d    = fault_pc_q;
    fetch_count_d = fetch_count_q;
    drop_d        = drop_q;
    imem_req      = 1'b0;
    ir_valid      = 1'b0;
    pc_advance    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (pc_in[1:0] != 2'b00) begin
          fault_pc_d    = pc_in;
          fetch_fault_d = 1'b1;
          state_d       = S_FAULT;
        end else begin
          imem_addr_d = pc_in;
          state_d     = S_REQ;
        end
      end
      S_REQ: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          // A flushed request still has to complete on the bus; its response is dropped here.
          if (drop_q || redirect) begin
            drop_d  = 1'b0;
            state_d = S_IDLE;
          end else if (imem_err) begin
            fault_pc_d    = imem_addr_q;
            fetch_fault_d = 1'b1;
            state_d       = S_FAULT;
          end else begin
            ir_d    = imem_rdata;
            ir_pc_d = imem_addr_q;
            state_d = S_HOLD;
          end
        end else if (redirect) begin
          drop_d = 1'b1;
        end
      end
      S_HOLD: begin
        ir_valid = 1'b1;
        if (redirect) begin
          state_d = S_IDLE;
        end else if (ir_ready) begin
          pc_advance    = 1'b1;
          fetch_count_d = fetch_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
          state_d       = S_IDLE;
        end
      end
      S_FAULT: begin
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign imem_addr   = imem_addr_q;
  assign ir          = ir_q;
  assign ir_pc       = ir_pc_q;
  assign op          = ir_q[31:26];
  assign jump_target = ir_q[25:0];
  assign imm         = ir_q[15:0];
  assign fetch_fault = fetch_fault_q;
  assign fault_pc    = fault_pc_q;
  assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: directed scenarios plus randomized fetches against a
// transaction-level expectation of what the decoder should receive.
module tb_ifetch_unit;

  logic        CLK = 1'b0;
  logic        RST;
  logic [31:0] pc_in;
  logic        redirect;
  logic        pc_advance;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        imem_err;
  logic        ir_valid;
  logic        ir_ready;
  logic [31:0] ir;
  logic [31:0] ir_pc;
  logic [5:0]  op;
  logic [25:0] jump_target;
  logic [15:0] imm;
  logic        fetch_fault;
  logic [31:0] fault_pc;
  logic [31:0] fetch_count;

  int          n_pass  = 0;
  int          n_total = 0;
  logic [31:0] exp_count = '0;

  ifetch_unit dut (
    .CLK(CLK), .RST(RST), .pc_in(pc_in), .redirect(redirect), .pc_advance(pc_advance),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .imem_err(imem_err), .ir_valid(ir_valid), .ir_ready(ir_ready), .ir(ir), .ir_pc(ir_pc),
    .op(op), .jump_target(jump_target), .imm(imm), .fetch_fault(fetch_fault),
    .fault_pc(fault_pc), .fetch_count(fetch_count)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    #1;
    tick();
    RST = 1'b0;
    exp_count = '0;
  endtask

  task automatic test_reset();
    n_total++; if (imem_req !== 1'b0 || ir_valid !== 1'b0 || pc_advance !== 1'b0)
      $display("FAIL reset_ctrl: req=%0b valid=%0b adv=%0b want 0 0 0", imem_req, ir_valid, pc_advance); else n_pass++;
    n_total++; if (imem_addr !== 32'h3000) $display("FAIL reset_addr: got %h want 00003000", imem_addr); else n_pass++;
    n_total++; if (ir !== 32'h0 || ir_pc !== 32'h0) $display("FAIL reset_ir: ir=%h ir_pc=%h want 0 0", ir, ir_pc); else n_pass++;
    n_total++; if (fetch_fault !== 1'b0 || fault_pc !== 32'h0 || fetch_count !== 32'h0)
      $display("FAIL reset_fault_cnt: fault=%0b fpc=%h cnt=%h want 0 0 0", fetch_fault, fault_pc, fetch_count); else n_pass++;
  endtask

  task automatic test_basic();
    pc_in = 32'h3000; imem_ack = 1'b1; imem_rdata = 32'h08000C01; imem_err = 1'b0; ir_ready = 1'b1; redirect = 1'b0;
    tick();
    n_total++; if (imem_req !== 1'b1 || imem_addr !== 32'h3000 || ir_valid !== 1'b0)
      $display("FAIL basic_req: req=%0b addr=%h valid=%0b want 1 3000 0", imem_req, imem_addr, ir_valid); else n_pass++;
    tick();
    n_total++; if (ir_valid !== 1'b1 || ir !== 32'h08000C01 || ir_pc !== 32'h3000)
      $display("FAIL basic_ir: valid=%0b ir=%h ir_pc=%h want 1 08000c01 3000", ir_valid, ir, ir_pc); else n_pass++;
    n_total++; if (op !== 6'h02 || jump_target !== 26'h0000C01 || imm !== 16'h0C01)
      $display("FAIL basic_fields: op=%h jt=%h imm=%h want 02 0000c01 0c01", op, jump_target, imm); else n_pass++;
    n_total++; if (pc_advance !== 1'b1) $display("FAIL basic_adv: got %0b want 1", pc_advance); else n_pass++;
    imem_ack = 1'b0;
    tick();
    exp_count++;
    n_total++; if (fetch_count !== exp_count || pc_advance !== 1'b0 || ir_valid !== 1'b0)
      $display("FAIL basic_done: cnt=%0d adv=%0b valid=%0b want %0d 0 0", fetch_count, pc_advance, ir_valid, exp_count); else n_pass++;
  endtask

  task automatic test_wait();
    int pulses = 0;
    logic [31:0] w = $urandom;
    pc_in = 32'h3004; imem_ack = 1'b0; ir_ready = 1'b1;
    tick();
    for (int i = 1; i <= 4; i++) begin
      n_total++; if (imem_req !== 1'b1 || imem_addr !== 32'h3004 || ir_valid !== 1'b0)
        $display("FAIL wait_stable c%0d: req=%0b addr=%h valid=%0b want 1 3004 0", i, imem_req, imem_addr, ir_valid); else n_pass++;
      pulses += int'(pc_advance);
      pc_in = $urandom & 32'hFFFF_FFFC;
      if (i == 4) begin imem_ack = 1'b1; imem_rdata = w; end
      tick();
    end
    n_total++; if (ir_valid !== 1'b1 || ir !== w || ir_pc !== 32'h3004)
      $display("FAIL wait_ir: valid=%0b ir=%h ir_pc=%h want 1 %h 3004", ir_valid, ir, ir_pc, w); else n_pass++;
    pulses += int'(pc_advance);
    imem_ack = 1'b0;
    tick();
    pulses += int'(pc_advance);
    exp_count++;
    n_total++; if (pulses != 1 || fetch_count !== exp_count)
      $display("FAIL wait_adv: pulses=%0d cnt=%0d want 1 %0d", pulses, fetch_count, exp_count); else n_pass++;
  endtask

  task automatic test_stall();
    logic [31:0] w = $urandom;
    pc_in = 32'h3008; imem_ack = 1'b1; imem_rdata = w; ir_ready = 1'b0;
    tick();
    tick();
    imem_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_total++; if (ir_valid !== 1'b1 || ir !== w || ir_pc !== 32'h3008 || pc_advance !== 1'b0 || fetch_count !== exp_count)
        $display("FAIL stall_hold c%0d: valid=%0b ir=%h ir_pc=%h adv=%0b cnt=%0d want 1 %h 3008 0 %0d",
                 i, ir_valid, ir, ir_pc, pc_advance, fetch_count, w, exp_count); else n_pass++;
      imem_rdata = $urandom;
      tick();
    end
    ir_ready = 1'b1;
    #1;
    n_total++; if (pc_advance !== 1'b1) $display("FAIL stall_adv: got %0b want 1", pc_advance); else n_pass++;
    tick();
    ir_ready = 1'b0;
    exp_count++;
    n_total++; if (fetch_count !== exp_count) $display("FAIL stall_cnt: got %0d want %0d", fetch_count, exp_count); else n_pass++;
  endtask

  task automatic test_redirect_req();
    logic [31:0] w = $urandom;
    pc_in = 32'h300C; imem_ack = 1'b0;
    tick();
    redirect = 1'b1;
    tick();
    redirect = 1'b0;
    n_total++; if (imem_req !== 1'b1 || imem_addr !== 32'h300C || ir_valid !== 1'b0)
      $display("FAIL redir_req_c2: req=%0b addr=%h valid=%0b want 1 300c 0", imem_req, imem_addr, ir_valid); else n_pass++;
    tick();
    n_total++; if (imem_req !== 1'b1 || ir_valid !== 1'b0)
      $display("FAIL redir_req_c3: req=%0b valid=%0b want 1 0", imem_req, ir_valid); else n_pass++;
    imem_ack = 1'b1; imem_rdata = 32'hDEADBEEF;
    tick();
    imem_ack = 1'b0;
    n_total++; if (imem_req !== 1'b0 || ir_valid !== 1'b0 || ir === 32'hDEADBEEF)
      $display("FAIL redir_req_drop: req=%0b valid=%0b ir=%h want 0 0 not-deadbeef", imem_req, ir_valid, ir); else n_pass++;
    pc_in = 32'h3010;
    tick();
    n_total++; if (imem_req !== 1'b1 || imem_addr !== 32'h3010)
      $display("FAIL redir_req_new: req=%0b addr=%h want 1 3010", imem_req, imem_addr); else n_pass++;
    imem_ack = 1'b1; imem_rdata = w; ir_ready = 1'b1;
    tick();
    n_total++; if (ir_valid !== 1'b1 || ir !== w || ir_pc !== 32'h3010)
      $display("FAIL redir_req_ir: valid=%0b ir=%h ir_pc=%h want 1 %h 3010", ir_valid, ir, ir_pc, w); else n_pass++;
    imem_ack = 1'b0;
    tick();
    ir_ready = 1'b0;
    exp_count++;
    n_total++; if (fetch_count !== exp_count) $display("FAIL redir_req_cnt: got %0d want %0d", fetch_count, exp_count); else n_pass++;
  endtask

  task automatic test_redirect_hold();
    pc_in = 32'h3014; imem_ack = 1'b1; imem_rdata = $urandom; ir_ready = 1'b0;
    tick();
    tick();
    imem_ack = 1'b0;
    redirect = 1'b1; ir_ready = 1'b1;
    #1;
    n_total++; if (ir_valid !== 1'b1 || pc_advance !== 1'b0)
      $display("FAIL redir_hold_adv: valid=%0b adv=%0b want 1 0", ir_valid, pc_advance); else n_pass++;
    tick();
    redirect = 1'b0; ir_ready = 1'b0;
    n_total++; if (ir_valid !== 1'b0 || fetch_count !== exp_count)
      $display("FAIL redir_hold_flush: valid=%0b cnt=%0d want 0 %0d", ir_valid, fetch_count, exp_count); else n_pass++;
  endtask

  // Per transaction: mode 0 normal, 1 redirect while waiting, 2 redirect with the ack, 3 redirect in HOLD.
  task automatic test_random();
    for (int t = 0; t < 40; t++) begin
      logic [31:0] pc   = $urandom & 32'hFFFF_FFFC;
      logic [31:0] word = $urandom;
      int mode = $urandom_range(0, 3);
      int w    = $urandom_range(0, 3);
      int d    = $urandom_range(0, 3);
      if (mode == 1 && w == 0) w = 1;
      pc_in = pc; imem_ack = 1'b0; redirect = 1'b0; ir_ready = 1'b0;
      tick();
      for (int i = 0; i < w; i++) begin
        imem_rdata = $urandom;
        redirect = (mode == 1 && i == 0);
        tick();
      end
      imem_ack = 1'b1; imem_rdata = word; redirect = (mode == 2);
      imem_err = (mode == 1 || mode == 2) ? 1'($urandom) : 1'b0;
      tick();
      imem_ack = 1'b0; imem_err = 1'b0; redirect = 1'b0;
      if (mode == 1 || mode == 2) begin
        n_total++; if (ir_valid !== 1'b0 || fetch_fault !== 1'b0 || fetch_count !== exp_count)
          $display("FAIL rnd_flush t%0d: valid=%0b fault=%0b cnt=%0d want 0 0 %0d", t, ir_valid, fetch_fault, fetch_count, exp_count); else n_pass++;
      end else begin
        n_total++; if (ir_valid !== 1'b1 || ir !== word || ir_pc !== pc)
          $display("FAIL rnd_ir t%0d: valid=%0b ir=%h ir_pc=%h want 1 %h %h", t, ir_valid, ir, ir_pc, word, pc); else n_pass++;
        for (int j = 0; j < d; j++) begin
          imem_ack = 1'($urandom);
          tick();
        end
        imem_ack = 1'b0; ir_ready = 1'b1; redirect = (mode == 3);
        #1;
        n_total++; if (pc_advance !== (mode != 3))
          $display("FAIL rnd_adv t%0d: got %0b want %0b", t, pc_advance, (mode != 3)); else n_pass++;
        tick();
        ir_ready = 1'b0; redirect = 1'b0;
        if (mode != 3) exp_count++;
        n_total++; if (fetch_count !== exp_count || ir_valid !== 1'b0)
          $display("FAIL rnd_cnt t%0d: cnt=%0d valid=%0b want %0d 0", t, fetch_count, ir_valid, exp_count); else n_pass++;
      end
    end
  endtask

  task automatic test_err();
    pc_in = 32'h3004; imem_ack = 1'b1; imem_err = 1'b1; imem_rdata = $urandom;
    tick();
    tick();
    imem_ack = 1'b0; imem_err = 1'b0;
    n_total++; if (fetch_fault !== 1'b1 || fault_pc !== 32'h3004 || imem_req !== 1'b0 || ir_valid !== 1'b0)
      $display("FAIL err_fault: fault=%0b fpc=%h req=%0b valid=%0b want 1 3004 0 0", fetch_fault, fault_pc, imem_req, ir_valid); else n_pass++;
    do_reset();
    n_total++; if (fetch_fault !== 1'b0 || fault_pc !== 32'h0)
      $display("FAIL err_clear: fault=%0b fpc=%h want 0 0", fetch_fault, fault_pc); else n_pass++;
  endtask

  task automatic test_misaligned();
    pc_in = 32'h3002; imem_ack = 1'b0;
    #1;
    n_total++; if (imem_req !== 1'b0) $display("FAIL misal_noreq_idle: got %0b want 0", imem_req); else n_pass++;
    tick();
    n_total++; if (fetch_fault !== 1'b1 || fault_pc !== 32'h3002 || imem_req !== 1'b0)
      $display("FAIL misal_fault: fault=%0b fpc=%h req=%0b want 1 3002 0", fetch_fault, fault_pc, imem_req); else n_pass++;
    for (int i = 0; i < 10; i++) begin
      redirect = 1'(i); imem_ack = 1'(i >> 1); ir_ready = 1'b1;
      pc_in = 32'h3000 + 32'(4 * i);
      tick();
      n_total++; if (fetch_fault !== 1'b1 || fault_pc !== 32'h3002 || imem_req !== 1'b0 || ir_valid !== 1'b0 || pc_advance !== 1'b0)
        $display("FAIL misal_sticky c%0d: fault=%0b fpc=%h req=%0b valid=%0b adv=%0b want 1 3002 0 0 0",
                 i, fetch_fault, fault_pc, imem_req, ir_valid, pc_advance); else n_pass++;
    end
    redirect = 1'b0; imem_ack = 1'b0; ir_ready = 1'b0;
    do_reset();
    n_total++; if (fetch_fault !== 1'b0 || fault_pc !== 32'h0)
      $display("FAIL misal_clear: fault=%0b fpc=%h want 0 0", fetch_fault, fault_pc); else n_pass++;
  endtask

  task automatic test_async_reset_wrap();
    logic [31:0] w = $urandom;
    pc_in = 32'h3018; imem_ack = 1'b0; ir_ready = 1'b0;
    tick();
    n_total++; if (imem_req !== 1'b1) $display("FAIL arst_pre: req=%0b want 1", imem_req); else n_pass++;
    #2 RST = 1'b1;
    #1;
    n_total++; if (imem_req !== 1'b0 || imem_addr !== 32'h3000 || ir_valid !== 1'b0)
      $display("FAIL arst_immediate: req=%0b addr=%h valid=%0b want 0 3000 0", imem_req, imem_addr, ir_valid); else n_pass++;
    tick();
    imem_ack = 1'b1; imem_rdata = $urandom;
    RST = 1'b0; exp_count = '0;
    pc_in = 32'h301C;
    tick();
    n_total++; if (imem_req !== 1'b1 || imem_addr !== 32'h301C || ir_valid !== 1'b0 || fetch_count !== 32'h0)
      $display("FAIL arst_stray: req=%0b addr=%h valid=%0b cnt=%0d want 1 301c 0 0", imem_req, imem_addr, ir_valid, fetch_count); else n_pass++;
    imem_rdata = w;
    tick();
    imem_ack = 1'b0;
    n_total++; if (ir_valid !== 1'b1 || ir !== w || ir_pc !== 32'h301C)
      $display("FAIL arst_fetch: valid=%0b ir=%h ir_pc=%h want 1 %h 301c", ir_valid, ir, ir_pc, w); else n_pass++;
    force dut.fetch_count_q = 32'hFFFF_FFFF;
    tick();
    tick();
    release dut.fetch_count_q;
    exp_count = 32'hFFFF_FFFF;
    #1;
    n_total++; if (fetch_count !== exp_count) $display("FAIL wrap_preload: got %h want %h", fetch_count, exp_count); else n_pass++;
    ir_ready = 1'b1;
    #1;
    n_total++; if (pc_advance !== 1'b1) $display("FAIL wrap_adv: got %0b want 1", pc_advance); else n_pass++;
    tick();
    ir_ready = 1'b0;
    exp_count++;
    n_total++; if (fetch_count !== exp_count || fetch_count !== 32'h0)
      $display("FAIL wrap_cnt: got %h want %h", fetch_count, exp_count); else n_pass++;
  endtask

  initial begin
    RST = 1'b1; pc_in = 32'h0; redirect = 1'b0; imem_ack = 1'b0; imem_rdata = 32'h0;
    imem_err = 1'b0; ir_ready = 1'b0;
    #3;
    test_reset();
    tick();
    RST = 1'b0;
    test_basic();
    test_wait();
    test_stall();
    test_redirect_req();
    test_redirect_hold();
    test_random();
    test_err();
    test_misaligned();
    test_async_reset_wrap();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
